// File: rtl/shared_delay_scheduler.sv
// shared_delay_scheduler
//   Round-robin owner of a single prescaled countdown timer shared by
//   NUM_REQ requesters. One requester at a time is granted the timer. Its
//   requested delay (in prescaled ticks) is counted down, and a one-cycle
//   done pulse is returned to it when the count expires. If the owner drops
//   its request before expiry, the job is abandoned and no done pulse is
//   produced.
//
// Parameters
//   NUM_REQ   number of requesters (2..8)
//   DELAY_W   width of each requested delay, in ticks
//   PRESCALE  clk cycles per tick (1..2^24-1); 1 = tick every cycle
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   req        level request per requester
//   delay_in   packed delays, slice i = delay_in[i*DELAY_W +: DELAY_W]
//   grant      one-hot owner of the timer, 0 when idle
//   done       one-cycle pulse to the owner on expiry
//   busy       high while a job is loaded, counting or completing
//   tick       prescaler tick, only pulses while counting
//   remaining  current countdown value, 0 when idle
module shared_delay_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int DELAY_W  = 16,
  parameter int PRESCALE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DELAY_W-1:0] delay_in,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic                       tick,
  output logic [DELAY_W-1:0]         remaining
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [23:0] PRESC_MAX = 24'(PRESCALE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [PTR_W-1:0]   ptr_next;
  logic [23:0]        presc;
  logic [DELAY_W-1:0] owner_delay;

  // Cyclic first-set search starting at the round-robin pointer, so the
  // requester just after the previous owner gets the highest priority.
  always_comb begin
    int               tmp;
    logic [PTR_W-1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    tmp        = 0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      tmp = int'(ptr) + i;
      if (tmp >= NUM_REQ) tmp = tmp - NUM_REQ;
      cand = PTR_W'(tmp);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign ptr_next    = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign owner_delay = delay_in[int'(owner)*DELAY_W +: DELAY_W];

  // Main FSM. tick is registered, so it is computed from the values the
  // prescaler and countdown will hold after this edge; it is suppressed once
  // the countdown has reached zero so a D-tick job yields exactly D pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      tick      <= 1'b0;
      remaining <= '0;
      presc     <= '0;
      ptr       <= '0;
      owner     <= '0;
    end else begin
      done <= '0;
      tick <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            owner <= pick_idx;
            grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!req[owner]) begin
            grant     <= '0;
            busy      <= 1'b0;
            remaining <= '0;
            presc     <= '0;
            ptr       <= ptr_next;
            state     <= S_IDLE;
          end else begin
            remaining <= owner_delay;
            presc     <= '0;
            tick      <= (owner_delay != '0) && (PRESC_MAX == 24'd0);
            state     <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (!req[owner]) begin
            grant     <= '0;
            busy      <= 1'b0;
            remaining <= '0;
            presc     <= '0;
            ptr       <= ptr_next;
            state     <= S_IDLE;
          end else if (remaining == '0) begin
            done  <= grant;
            state <= S_DONE;
          end else if (presc == PRESC_MAX) begin
            presc     <= '0;
            remaining <= remaining - 1'b1;
            tick      <= (remaining != DELAY_W'(1)) && (PRESC_MAX == 24'd0);
          end else begin
            presc <= presc + 24'd1;
            tick  <= ((presc + 24'd1) == PRESC_MAX);
          end
        end
        S_DONE: begin
          grant <= '0;
          busy  <= 1'b0;
          ptr   <= ptr_next;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_delay_scheduler.sv
module tb_shared_delay_scheduler;

   localparam int NUM_REQ = 4;
   localparam int DELAY_W = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // dut1 runs with PRESCALE=1, dut3 with PRESCALE=3
   logic        rst, rst3;
   logic [3:0]  req, req3;
   logic [63:0] delay_in, delay3;
   logic [3:0]  grant, done, grant3, done3;
   logic        busy, tick, busy3, tick3;
   logic [15:0] remaining, remaining3;

   shared_delay_scheduler #(.NUM_REQ(NUM_REQ), .DELAY_W(DELAY_W), .PRESCALE(1)) dut1 (
      .clk(clk), .rst(rst), .req(req), .delay_in(delay_in),
      .grant(grant), .done(done), .busy(busy), .tick(tick), .remaining(remaining)
   );

   shared_delay_scheduler #(.NUM_REQ(NUM_REQ), .DELAY_W(DELAY_W), .PRESCALE(3)) dut3 (
      .clk(clk), .rst(rst3), .req(req3), .delay_in(delay3),
      .grant(grant3), .done(done3), .busy(busy3), .tick(tick3), .remaining(remaining3)
   );

   int checks = 0;
   int fails  = 0;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [3:0]  grant;
      logic [3:0]  done;
      logic        busy;
      logic        tick;
      logic [15:0] remaining;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] g, logic [3:0] d,
                               logic b, logic t, logic [15:0] rem);
      vec_t v;
      v.rst = r; v.req = rq; v.grant = g; v.done = d;
      v.busy = b; v.tick = t; v.remaining = rem;
      return v;
   endfunction

   // Drive the PRESCALE=1 instance inputs
   task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [63:0] d);
      rst      = r;
      req      = rq;
      delay_in = d;
   endtask

   // One comparison: counted, and reported on mismatch
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Main sequence: table, then prescaled ticks, round robin, abort, reset
   initial begin
      logic [3:0] gOrder[4];
      int         gCycle[4];
      int         dCycle[4];
      logic [3:0] dVal[4];
      int         nGrant, nDone, nTick, tickAt[2], doneAt;
      logic [3:0] prevGrant, doneSeen;
      logic       saw2, found;

      rst3   = 1'b1;
      req3   = '0;
      delay3 = '0;

      // Reset held with all requests high, then requester 2 asks for 5 ticks
      vecs[0]  = mk(1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 16'd0);
      vecs[1]  = mk(1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 16'd0);
      vecs[2]  = mk(1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 16'd0);
      vecs[3]  = mk(0, 4'b0100, 4'b0100, 4'b0000, 1, 0, 16'd0);
      vecs[4]  = mk(0, 4'b0100, 4'b0100, 4'b0000, 1, 1, 16'd5);
      vecs[5]  = mk(0, 4'b0100, 4'b0100, 4'b0000, 1, 1, 16'd4);
      vecs[6]  = mk(0, 4'b0100, 4'b0100, 4'b0000, 1, 1, 16'd3);
      vecs[7]  = mk(0, 4'b0100, 4'b0100, 4'b0000, 1, 1, 16'd2);
      vecs[8]  = mk(0, 4'b0100, 4'b0100, 4'b0000, 1, 1, 16'd1);
      vecs[9]  = mk(0, 4'b0100, 4'b0100, 4'b0000, 1, 0, 16'd0);
      vecs[10] = mk(0, 4'b0100, 4'b0100, 4'b0100, 1, 0, 16'd0);
      vecs[11] = mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'd0);
      vecs[12] = mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'd0);

      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].req, {4{16'd5}});
         cycle();
         checkOutput($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].grant));
         checkOutput($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].done));
         checkOutput($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
         checkOutput($sformatf("v%0d tick", i), 32'(tick), 32'(vecs[i].tick));
         checkOutput($sformatf("v%0d remaining", i), 32'(remaining), 32'(vecs[i].remaining));
      end

      // PRESCALE=3, requester 0 asks for 2 ticks
      rst3   = 1'b0;
      req3   = 4'b0001;
      delay3 = 64'd2;
      nTick  = 0;
      doneAt = -1;
      nDone  = 0;
      tickAt[0] = -1;
      tickAt[1] = -1;
      for (int c = 1; c <= 14; c++) begin
         cycle();
         if (c == 1) checkOutput("p3 grant", 32'(grant3), 32'h1);
         if (tick3) begin
            if (nTick < 2) tickAt[nTick] = c;
            nTick++;
         end
         if (done3 != '0) begin
            checkOutput("p3 done owner", 32'(done3), 32'h1);
            nDone++;
            doneAt = c;
            req3   = '0;
         end
      end
      checkOutput("p3 tick count", 32'(nTick), 32'd2);
      checkOutput("p3 first tick", 32'(tickAt[0]), 32'd4);
      checkOutput("p3 tick spacing", 32'(tickAt[1] - tickAt[0]), 32'd3);
      checkOutput("p3 done cycle", 32'(doneAt), 32'd9);
      checkOutput("p3 done count", 32'(nDone), 32'd1);

      // Round robin with req=1011 held and zero delays
      applyStimulus(1, 4'b0000, '0);
      cycle();
      applyStimulus(0, 4'b1011, '0);
      nGrant    = 0;
      nDone     = 0;
      prevGrant = '0;
      saw2      = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         cycle();
         if (grant[2]) saw2 = 1'b1;
         if (prevGrant == '0 && grant != '0 && nGrant < 4) begin
            gOrder[nGrant] = grant;
            gCycle[nGrant] = c;
            nGrant++;
         end
         if (done != '0 && nDone < 4) begin
            dVal[nDone]   = done;
            dCycle[nDone] = c;
            nDone++;
         end
         prevGrant = grant;
      end
      checkOutput("rr grant count", 32'(nGrant), 32'd4);
      checkOutput("rr done count", 32'(nDone), 32'd4);
      checkOutput("rr req2 never granted", 32'(saw2), 32'd0);
      if (nGrant == 4 && nDone == 4) begin
         checkOutput("rr grant 0", 32'(gOrder[0]), 32'b0001);
         checkOutput("rr grant 1", 32'(gOrder[1]), 32'b0010);
         checkOutput("rr grant 2", 32'(gOrder[2]), 32'b1000);
         checkOutput("rr grant 3", 32'(gOrder[3]), 32'b0001);
         for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("rr done owner %0d", k), 32'(dVal[k]), 32'(gOrder[k]));
            checkOutput($sformatf("rr done latency %0d", k), 32'(dCycle[k] - gCycle[k]), 32'd2);
         end
      end

      // Abort: requester 1 drops its request at remaining=4
      applyStimulus(1, 4'b0000, '0);
      cycle();
      applyStimulus(0, 4'b0010, {4{16'd6}});
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         cycle();
         if (grant == 4'b0010 && remaining == 16'd4) found = 1'b1;
      end
      checkOutput("abort reached rem4", 32'(found), 32'd1);
      applyStimulus(0, 4'b0101, {4{16'd6}});
      cycle();
      checkOutput("abort grant", 32'(grant), 32'd0);
      checkOutput("abort done", 32'(done), 32'd0);
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort remaining", 32'(remaining), 32'd0);
      cycle();
      checkOutput("abort next grant", 32'(grant), 32'b0100);
      found    = 1'b0;
      doneSeen = '0;
      for (int n = 0; n < 20 && !found; n++) begin
         cycle();
         if (done != '0) begin
            found    = 1'b1;
            doneSeen = done;
            applyStimulus(0, 4'b0000, {4{16'd6}});
         end
      end
      checkOutput("abort follow-up done", 32'(doneSeen), 32'b0100);
      cycle();

      // Reset mid-count, then priority restarts from requester 0
      applyStimulus(0, 4'b1000, {4{16'd10}});
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         cycle();
         if (remaining == 16'd7) found = 1'b1;
      end
      checkOutput("rst reached rem7", 32'(found), 32'd1);
      checkOutput("rst owner before", 32'(grant), 32'b1000);
      applyStimulus(1, 4'b1000, {4{16'd10}});
      cycle();
      checkOutput("rst grant", 32'(grant), 32'd0);
      checkOutput("rst done", 32'(done), 32'd0);
      checkOutput("rst busy", 32'(busy), 32'd0);
      checkOutput("rst tick", 32'(tick), 32'd0);
      checkOutput("rst remaining", 32'(remaining), 32'd0);
      applyStimulus(0, 4'b1001, {4{16'd10}});
      cycle();
      checkOutput("post-rst grant", 32'(grant), 32'b0001);
      found    = 1'b0;
      doneSeen = '0;
      for (int n = 0; n < 30 && !found; n++) begin
         cycle();
         if (done != '0) begin
            found    = 1'b1;
            doneSeen = done;
            applyStimulus(0, 4'b1000, {4{16'd10}});
         end
      end
      checkOutput("post-rst done 0", 32'(doneSeen), 32'b0001);
      found    = 1'b0;
      doneSeen = '0;
      for (int n = 0; n < 30 && !found; n++) begin
         cycle();
         if (done != '0) begin
            found    = 1'b1;
            doneSeen = done;
            applyStimulus(0, 4'b0000, {4{16'd10}});
         end
      end
      checkOutput("post-rst done 3", 32'(doneSeen), 32'b1000);
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
